// File: rtl/fetch_pkg.sv
// Types and sizing helpers shared by the instruction prefetch queue and the decoder.
package fetch_pkg;

  localparam int FQ_DEPTH_MAX  = 16;
  localparam int FQ_ADDR_WIDTH = 16;

  typedef struct packed {
    logic [7:0]               data;
    logic [FQ_ADDR_WIDTH-1:0] pc;
  } fq_entry_t;

  function automatic int fq_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fq_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a flush that overrides push and pop.
// Pops on an empty FIFO and pushes on a full one (without a pop) are ignored.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             flush,
  input  logic [WIDTH-1:0]                 dataIn,
  output logic [WIDTH-1:0]                 dataOut,
  output logic [fq_count_width(DEPTH)-1:0] count
);

  localparam int            CW       = fq_count_width(DEPTH);
  localparam int            PW       = fq_ptr_width(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? {PW{1'b0}} : ptr + PW'(1);
  endfunction

  assign w_do_pop  = pop && !flush && (r_count != {CW{1'b0}});
  assign w_do_push = push && !flush && ((r_count != CNT_FULL) || w_do_pop);

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_do_push && !reset) begin
      r_mem[r_wr_ptr] <= dataIn;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dataOut = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch unit: streams program bytes into an address-tagged queue
// so decode can take one byte per cycle; a jump flushes and redirects fetch.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic [ADDR_WIDTH-1:0]            memAddr,
  output logic                             memStrobe,
  input  logic [7:0]                       memDataRead,
  output logic [7:0]                       outByte,
  output logic [ADDR_WIDTH-1:0]            outPc,
  output logic                             outValid,
  input  logic                             consume,
  input  logic                             jumpEn,
  input  logic [ADDR_WIDTH-1:0]            jumpAddr,
  output logic [fq_count_width(DEPTH)-1:0] count
);

  localparam int CW = fq_count_width(DEPTH);
  localparam int OW = CW + 1;
  localparam int EW = 8 + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_pend_pc;
  logic                  r_pending;
  logic                  w_strobe;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic [OW-1:0]         w_occupancy;
  logic [CW-1:0]         w_count;
  logic [EW-1:0]         w_head;

  // Slots already spoken for include the read still in flight, so issue stops
  // before the queue could overflow; a same-cycle pop does not free a slot.
  assign w_occupancy = OW'(w_count) + OW'(r_pending);
  assign w_strobe    = !reset && !jumpEn && (w_occupancy < OW'(DEPTH));
  assign w_valid     = (w_count != {CW{1'b0}});
  assign w_push      = r_pending && !jumpEn;
  assign w_pop       = consume && w_valid;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (jumpEn),
    .dataIn  ({memDataRead, r_pend_pc}),
    .dataOut (w_head),
    .count   (w_count)
  );

  // Fetch address and in-flight read tracking; a jump drops the outstanding read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= RESET_PC;
      r_pending  <= 1'b0;
    end else if (jumpEn) begin
      r_fetch_pc <= jumpAddr;
      r_pending  <= 1'b0;
    end else begin
      r_pending <= w_strobe;
      if (w_strobe) begin
        r_pend_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
      end
    end
  end

  assign memAddr   = r_fetch_pc;
  assign memStrobe = w_strobe;
  assign outValid  = w_valid;
  assign count     = w_count;
  // Queue storage is not reset, so an empty queue presents the reset values.
  assign outByte   = w_valid ? w_head[EW-1 -: 8] : 8'h00;
  assign outPc     = w_valid ? w_head[ADDR_WIDTH-1:0] : RESET_PC;

endmodule
